// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_pkg
//  Purpose  : Shared defaults, requester ids and constants for the register
//             bank write-port controller.
//  Revision : 1.0 - initial release
// ============================================================================
package regbank_pkg;

    localparam int NREQ_DEFAULT = 3;
    localparam int AW_DEFAULT   = 5;
    localparam int DW_DEFAULT   = 32;

    // Fixed requester slots on the shared write port
    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_LOAD = 2'd1,
        REQ_DBG  = 2'd2
    } req_id_e;

    // Register $0 is hard-wired; writes to it are swallowed
    localparam logic [AW_DEFAULT-1:0] REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/regbank_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_wr_ctrl_if
//  Purpose  : Requester handshake, bank write port, decode read addresses and
//             hazard/status outputs of the write-port controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface regbank_wr_ctrl_if
    import regbank_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int DW   = DW_DEFAULT
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               RegWrite;
    logic [AW-1:0]      wrAddr;
    logic [DW-1:0]      wrData;
    logic [1:0]         grant_id;
    logic [AW-1:0]      rdAddrA;
    logic [AW-1:0]      rdAddrB;
    logic               hazA;
    logic               hazB;
    logic [15:0]        wr_count;

    // Requesters / decode stage side
    modport master (
        output req_valid, req_addr, req_data, rdAddrA, rdAddrB,
        input  req_ready, RegWrite, wrAddr, wrData, grant_id, hazA, hazB, wr_count
    );

    // Controller side
    modport slave (
        input  req_valid, req_addr, req_data, rdAddrA, rdAddrB,
        output req_ready, RegWrite, wrAddr, wrData, grant_id, hazA, hazB, wr_count
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick: first requesting index at or
//             after ptr, searched cyclically. One-hot grant plus encoded id.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import regbank_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_id
);

    int   w_idx;
    logic w_found;

    // Cyclic priority search starting at ptr; nothing granted when disabled
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (en && !w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = 2'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regbank_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regbank_wr_ctrl
//  Purpose  : Shares the single register-bank write port between the ALU,
//             load and debug writeback sources through a round-robin grant
//             and one register stage; flags RAW hazards for both read ports.
//  Revision : 1.0 - initial release
// ============================================================================
module regbank_wr_ctrl
    import regbank_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arb_en,
    regbank_wr_ctrl_if.slave   bus
);

    localparam logic [1:0]    c_LAST = 2'(NREQ - 1);
    localparam logic [AW-1:0] c_ZERO = AW'(REG_ZERO);

    logic [1:0]      r_ptr;
    logic            r_regWrite;
    logic [AW-1:0]   r_wrAddr;
    logic [DW-1:0]   r_wrData;
    logic [1:0]      r_grantId;
    logic [15:0]     r_wrCount;

    logic [NREQ-1:0] w_gnt;
    logic [1:0]      w_gntId;
    logic            w_xfer;
    logic            w_arbEn;
    logic [AW-1:0]   w_selAddr;
    logic [DW-1:0]   w_selData;
    logic            w_hazA;
    logic            w_hazB;

    // Grants are forced off while reset is held so ready reads 0
    assign w_arbEn = arb_en & reset;

    rr_arbiter #(
        .NREQ   (NREQ)
    ) u_arb (
        .req    (bus.req_valid),
        .ptr    (r_ptr),
        .en     (w_arbEn),
        .gnt    (w_gnt),
        .gnt_id (w_gntId)
    );

    assign w_xfer    = |w_gnt;
    assign w_selAddr = bus.req_addr[w_gntId*AW +: AW];
    assign w_selData = bus.req_data[w_gntId*DW +: DW];

    // Write stage: latch the winner; $0 consumes a slot but never pulses RegWrite
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= 2'd0;
            r_regWrite <= 1'b0;
            r_wrAddr   <= '0;
            r_wrData   <= '0;
            r_grantId  <= 2'd0;
        end else if (w_xfer) begin
            r_ptr      <= (w_gntId == c_LAST) ? 2'd0 : w_gntId + 2'd1;
            r_regWrite <= (w_selAddr != c_ZERO);
            r_wrAddr   <= w_selAddr;
            r_wrData   <= w_selData;
            r_grantId  <= w_gntId;
        end else begin
            r_regWrite <= 1'b0;
        end
    end

    // Saturating count of cycles that actually wrote the bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrCount <= 16'd0;
        end else if (r_regWrite && (r_wrCount != 16'hFFFF)) begin
            r_wrCount <= r_wrCount + 16'd1;
        end
    end

    // RAW hazards against the in-flight write and every pending request
    always_comb begin
        w_hazA = 1'b0;
        w_hazB = 1'b0;
        if (reset) begin
            if (r_regWrite && (r_wrAddr == bus.rdAddrA)) w_hazA = 1'b1;
            if (r_regWrite && (r_wrAddr == bus.rdAddrB)) w_hazB = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.req_valid[i] && (bus.req_addr[i*AW +: AW] == bus.rdAddrA)) w_hazA = 1'b1;
                if (bus.req_valid[i] && (bus.req_addr[i*AW +: AW] == bus.rdAddrB)) w_hazB = 1'b1;
            end
            if (bus.rdAddrA == c_ZERO) w_hazA = 1'b0;
            if (bus.rdAddrB == c_ZERO) w_hazB = 1'b0;
        end
    end

    assign bus.req_ready = w_gnt;
    assign bus.RegWrite  = r_regWrite;
    assign bus.wrAddr    = r_wrAddr;
    assign bus.wrData    = r_wrData;
    assign bus.grant_id  = r_grantId;
    assign bus.wr_count  = r_wrCount;
    assign bus.hazA      = w_hazA;
    assign bus.hazB      = w_hazB;

endmodule
`default_nettype wire

// File: tb/tb_regbank_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbank_wr_ctrl
//  Purpose  : Self-checking bench for regbank_wr_ctrl: behavioural model plus
//             per-cycle compare, directed scenarios and randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regbank_wr_ctrl;
    import regbank_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic arb_en = 1'b0;

    always #5 clk = ~clk;

    regbank_wr_ctrl_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    regbank_wr_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .reset  (reset),
        .arb_en (arb_en),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_ptr     = 0;
    logic          m_rw      = 1'b0;
    logic [AW-1:0] m_wa      = '0;
    logic [DW-1:0] m_wd      = '0;
    int            m_gid     = 0;
    int            m_cnt     = 0;
    int            m_lastGnt = -1;
    int            mWin;

    // Who should win now: first valid requester at/after ptr, cyclically
    function automatic int winner(input logic [NREQ-1:0] v, input logic en, input logic rn, input int p);
        if (!rn || !en) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic expHaz(input logic [AW-1:0] rd);
        if (!reset || rd == '0) return 1'b0;
        if (m_rw && m_wa == rd) return 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && bus.req_addr[i*AW +: AW] == rd) return 1'b1;
        end
        return 1'b0;
    endfunction

    always_comb mWin = winner(bus.req_valid, arb_en, reset, m_ptr);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ptr <= 0; m_rw <= 1'b0; m_wa <= '0; m_wd <= '0;
            m_gid <= 0; m_cnt <= 0; m_lastGnt <= -1;
        end else begin
            if (m_rw && m_cnt < 65535) m_cnt <= m_cnt + 1;
            m_lastGnt <= mWin;
            if (mWin >= 0) begin
                m_rw  <= (bus.req_addr[mWin*AW +: AW] != '0);
                m_wa  <= bus.req_addr[mWin*AW +: AW];
                m_wd  <= bus.req_data[mWin*DW +: DW];
                m_gid <= mWin;
                m_ptr <= (mWin + 1) % NREQ;
            end else begin
                m_rw <= 1'b0;
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        chk("m_req_ready", 64'(bus.req_ready), (mWin < 0) ? 64'd0 : (64'd1 << mWin));
        chk("m_RegWrite",  64'(bus.RegWrite),  64'(m_rw));
        chk("m_wrAddr",    64'(bus.wrAddr),    64'(m_wa));
        chk("m_wrData",    64'(bus.wrData),    64'(m_wd));
        chk("m_grant_id",  64'(bus.grant_id),  64'(m_gid));
        chk("m_wr_count",  64'(bus.wr_count),  64'(m_cnt));
        chk("m_hazA",      64'(bus.hazA),      64'(expHaz(bus.rdAddrA)));
        chk("m_hazB",      64'(bus.hazB),      64'(expHaz(bus.rdAddrB)));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]          = v;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_data[i*DW +: DW]  = d;
    endtask

    task automatic dropAll();
        for (int i = 0; i < NREQ; i++) setReq(i, 1'b0, '0, '0);
    endtask

    task automatic doReset();
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rdAddrA   = '0;
        bus.rdAddrB   = '0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Reset state
        probe();
        chk("rst_RegWrite", 64'(bus.RegWrite), 64'd0);
        chk("rst_wrAddr",   64'(bus.wrAddr),   64'd0);
        chk("rst_wr_count", 64'(bus.wr_count), 64'd0);
        chk("rst_grant_id", 64'(bus.grant_id), 64'd0);

        // Single ALU write
        cyc();
        arb_en = 1'b1;
        setReq(int'(REQ_ALU), 1'b1, 5'd10, 32'h15);
        probe();
        chk("alu_ready", 64'(bus.req_ready), 64'b001);
        cyc();
        dropAll();
        probe();
        chk("alu_RegWrite", 64'(bus.RegWrite), 64'd1);
        chk("alu_wrAddr",   64'(bus.wrAddr),   64'd10);
        chk("alu_wrData",   64'(bus.wrData),   64'h15);
        chk("alu_grant_id", 64'(bus.grant_id), 64'd0);
        cyc();
        probe();
        chk("alu_wr_count", 64'(bus.wr_count), 64'd1);

        // Same register from ALU and LOAD with ptr at 1
        cyc();
        setReq(int'(REQ_ALU),  1'b1, 5'd15, 32'd3);
        setReq(int'(REQ_LOAD), 1'b1, 5'd15, 32'd7);
        bus.rdAddrA = 5'd15;
        probe();
        chk("dup_ready1", 64'(bus.req_ready), 64'b010);
        chk("dup_hazA1",  64'(bus.hazA),      64'd1);
        cyc();
        setReq(int'(REQ_LOAD), 1'b0, '0, '0);
        probe();
        chk("dup_ready2", 64'(bus.req_ready), 64'b001);
        chk("dup_wrData1", 64'(bus.wrData),   64'd7);
        chk("dup_gid1",   64'(bus.grant_id),  64'd1);
        cyc();
        setReq(int'(REQ_ALU), 1'b0, '0, '0);
        probe();
        chk("dup_RegWrite2", 64'(bus.RegWrite), 64'd1);
        chk("dup_hazA2",     64'(bus.hazA),     64'd1);
        cyc();
        probe();
        chk("dup_final_wrData", 64'(bus.wrData), 64'd3);
        chk("dup_hazA_clear",   64'(bus.hazA),   64'd0);
        bus.rdAddrA = '0;

        // Three requesters held for six cycles from ptr 0
        doReset();
        for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, 5'(i + 1), 32'hA0 + 32'(i));
        for (int c = 0; c < 6; c++) begin
            probe();
            chk($sformatf("rr_ready_%0d", c), 64'(bus.req_ready), 64'd1 << (c % 3));
            if (c > 0) begin
                chk($sformatf("rr_RegWrite_%0d", c), 64'(bus.RegWrite), 64'd1);
                chk($sformatf("rr_gid_%0d", c),      64'(bus.grant_id), 64'((c - 1) % 3));
            end
            cyc();
        end
        dropAll();
        probe();
        chk("rr_last_RegWrite", 64'(bus.RegWrite), 64'd1);
        chk("rr_count5",        64'(bus.wr_count), 64'd5);
        cyc();
        for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, 5'd1, 32'hB0);
        probe();
        chk("rr_ptr_back0", 64'(bus.req_ready), 64'b001);
        chk("rr_count6",    64'(bus.wr_count),  64'd6);

        // LOAD to $0 consumes a slot without a bank write
        cyc();
        dropAll();
        setReq(int'(REQ_LOAD), 1'b1, 5'd0, 32'hFFFF_FFFF);
        probe();
        chk("z_ready", 64'(bus.req_ready), 64'b010);
        cyc();
        dropAll();
        probe();
        chk("z_RegWrite", 64'(bus.RegWrite), 64'd0);
        chk("z_wrAddr",   64'(bus.wrAddr),   64'd0);
        chk("z_count",    64'(bus.wr_count), 64'd7);
        cyc();
        probe();
        chk("z_count_hold", 64'(bus.wr_count), 64'd7);

        // Reset right after a grant discards the in-flight write
        cyc();
        setReq(int'(REQ_ALU), 1'b1, 5'd9, 32'h99);
        probe();
        chk("rst_mid_ready", 64'(bus.req_ready), 64'b001);
        cyc();
        dropAll();
        reset = 1'b0;
        #1;
        chk("rst_mid_RegWrite", 64'(bus.RegWrite), 64'd0);
        chk("rst_mid_count",    64'(bus.wr_count), 64'd0);
        cyc();
        reset = 1'b1;
        probe();
        chk("rst_rel_RegWrite", 64'(bus.RegWrite), 64'd0);
        cyc();
        for (int i = 0; i < NREQ; i++) setReq(i, 1'b1, 5'd4, 32'hC0);
        probe();
        chk("rst_rel_ptr0", 64'(bus.req_ready), 64'b001);
        cyc();
        dropAll();

        // arb_en low holds DBG off while hazard stays visible
        arb_en = 1'b0;
        setReq(int'(REQ_DBG), 1'b1, 5'd5, 32'h55);
        bus.rdAddrA = 5'd5;
        for (int c = 0; c < 4; c++) begin
            probe();
            chk($sformatf("en_ready_%0d", c), 64'(bus.req_ready), 64'd0);
            chk($sformatf("en_hazA_%0d", c),  64'(bus.hazA),      64'd1);
            cyc();
        end
        arb_en = 1'b1;
        probe();
        chk("en_grant", 64'(bus.req_ready), 64'b100);
        cyc();
        dropAll();
        probe();
        chk("en_gid",    64'(bus.grant_id), 64'd2);
        chk("en_wrAddr", 64'(bus.wrAddr),   64'd5);

        // Randomized traffic; requesters hold until granted, sometimes withdraw
        for (int n = 0; n < 3000; n++) begin
            cyc();
            reset = ((n % 700) == 350) ? 1'b0 : 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] || m_lastGnt == i || $urandom_range(0, 19) == 0) begin
                    setReq(i, ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), 32'($urandom));
                end
            end
            arb_en      = ($urandom_range(0, 9) != 0);
            bus.rdAddrA = 5'($urandom_range(0, 7));
            bus.rdAddrB = 5'($urandom_range(0, 7));
        end

        cyc();
        dropAll();
        reset = 1'b1;
        probe();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regbank_wr_ctrl.md
# regbank_wr_ctrl

Write-port controller for the KGP-RISC register bank. The bank has one write port, and this block shares it between up to three writeback sources: ALU writeback, load writeback and debug/loader. A round-robin arbiter grants one source per cycle and drives the bank's `RegWrite`/`wrAddr`/`wrData` through one register stage. For the decode stage, it flags read-after-write hazards on both read ports against pending and in-flight writes.

## Interface
Parameters:
- `NREQ`, 3, number of write requesters (2..4)
- `AW`, 5, register address width
- `DW`, 32, register data width

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low; clears all state immediately
- `arb_en`  in  1  when low, no grants are issued and pending requests wait
- `req_valid`  in  NREQ  per-requester write request
- `req_ready`  out  NREQ  per-requester grant; one-hot or zero
- `req_addr`  in  NREQ*AW  destination register; requester i uses slice [i*AW +: AW]
- `req_data`  in  NREQ*DW  write data; requester i uses slice [i*DW +: DW]
- `RegWrite`  out  1  write enable to the register bank (registered)
- `wrAddr`  out  AW  write address to the register bank (registered)
- `wrData`  out  DW  write data to the register bank (registered)
- `grant_id`  out  2  requester index of the current `RegWrite` cycle (registered)
- `rdAddrA`, `rdAddrB`  in  AW  decode read addresses, mirrored from the bank inputs
- `hazA`, `hazB`  out  1  combinational RAW hazard flags
- `wr_count`  out  16  saturating count of committed writes

## Operation
- Handshake: a transfer happens on requester i in any cycle where `req_valid[i] && req_ready[i]`.
  - Once `req_valid[i]` is raised, the requester holds valid, addr and data stable until accepted.
  - If valid drops early, the block treats the request as withdrawn; this is not an error.
- Arbitration: when `arb_en` is high and any valid bit is set, exactly one `req_ready` bit is asserted.
  - The winner is the first valid index at or after `ptr`, searching cyclically.
  - `ready` depends combinationally on `valid`.
  - After a grant, `ptr` ← (winner+1) mod NREQ.
  - With no grant, `ptr` holds.
  - Reset value of `ptr` is 0.
- Write stage, on an accepted transfer:
  - `wrAddr` ← addr, `wrData` ← data, `grant_id` ← winner.
  - `RegWrite` ← (addr != 0). A write to $0 is accepted and consumes a slot, but is never issued to the bank.
- Write stage, with no transfer: `RegWrite` ← 0; `wrAddr`, `wrData` and `grant_id` hold.
- `wr_count` increments on every cycle where `RegWrite` is high and saturates at 16'hFFFF.
- Hazard rule for `hazA` (`hazB` is the same with `rdAddrB`): high when `rdAddrA != 0` and either
  - `RegWrite && wrAddr == rdAddrA`, or
  - for some i, `req_valid[i] && req_addr[i] == rdAddrA`.
- Same register requested by two sources in one cycle: only the round-robin winner is granted. The loser writes in a later grant, so the last write in grant order wins.
- Reset values: `RegWrite`=0, `wrAddr`=0, `wrData`=0, `grant_id`=0, `wr_count`=0, `ptr`=0.
  - Outputs `req_ready`, `hazA` and `hazB` are combinational and evaluate to 0 while `reset` is low.
- Reset asserted mid-operation: any in-flight write is discarded, with no `RegWrite` pulse after reset. Requesters that were not granted re-present their requests after reset release.

## Timing
- Latency: request accepted in cycle N → `RegWrite` high in cycle N+1 → bank updated at the rising edge ending N+1.
- Throughput: one write per cycle. Back-to-back grants give continuous `RegWrite`.
- Fairness: a continuously valid requester waits at most NREQ-1 cycles for a grant while `arb_en` is high.
- `arb_en` falling in cycle N blocks grants in N. A write accepted in N-1 still issues in N.
- Hazard flags are valid in the same cycle as the read addresses. They clear in the cycle after the last matching `RegWrite`.

## Structure
- Shared package `regbank_pkg` holds:
  - `AW`, `DW` and `NREQ` defaults
  - requester ids `REQ_ALU`=0, `REQ_LOAD`=1, `REQ_DBG`=2
  - the `REG_ZERO` constant
- One sub-module, `rr_arbiter`: parameterised NREQ, taking `req`, `ptr` and `en` and producing one-hot `gnt` and encoded `gnt_id`.
- Write-stage registers, `ptr`, counter and hazard compare live in `regbank_wr_ctrl`.

## Test plan
- Reset, then a single ALU write (addr 10, data 32'h15) → `req_ready[0]` the same cycle; next cycle `RegWrite`=1, `wrAddr`=10, `wrData`=32'h15, `grant_id`=0; `wr_count`=1.
- All three requesters valid and held for 6 cycles (addr 1, 2, 3) → grant order 0,1,2,0,1,2; `RegWrite` high for 6 consecutive cycles; `ptr` back at 0.
- LOAD writes addr 0 with data 32'hFFFF_FFFF → `req_ready[1]`=1; next cycle `RegWrite`=0 and `wr_count` unchanged.
- ALU and LOAD both target addr 15 (data 3 and 7), `ptr`=1 → LOAD granted first, then ALU; final `wrData`=3. `rdAddrA`=15 gives `hazA`=1 until the cycle after the second `RegWrite`.
- Assert `reset` in the cycle after a grant → `RegWrite` drops to 0 immediately, no write after release, `wr_count`=0, `ptr`=0.
- `arb_en`=0 with DBG valid (addr 5) for 4 cycles → `req_ready`=0 and `hazA`=1 for `rdAddrA`=5; raise `arb_en` → grant the same cycle.
